transfer_receiver: RTL and testbench
====================================

Name: transfer_receiver

Overview:
Receiving end of the scanner's serial transfer link. Drives the handshake that enables the scanner's transfer and deserializes its clkOut/dataOut stream MSB-first into 8-bit bytes. Completed bytes are queued in a small FIFO for the downstream consumer. Sits directly downstream of the scanner: its readyForTransfer drives the scanner's readyForTransferIn.

Parameters:
DATA_WIDTH, 8, bits per transferred byte
BURST_BYTES, 2, bytes per scanner transfer burst
FIFO_DEPTH, 8, receive queue entries (power of 2, >= BURST_BYTES)
TIMEOUT_CYCLES, 64, clk cycles without a serial clock edge before a partial byte is abandoned

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  reset, asynchronous, active-high
serialClkIn  input  1  scanner clkOut; data is sampled on its rising edge
serialDataIn  input  1  scanner dataOut, MSB first
readEnable  input  1  consumer pop request
readyForTransfer  output  1  to scanner readyForTransferIn
dataOutByte  output  DATA_WIDTH  FIFO head
dataValid  output  1  FIFO not empty
byteCount  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
frameError  output  1  one-cycle pulse on timeout abort
overflow  output  1  sticky; a write was attempted while the FIFO was full
ps  output  2  current state, for debug

Behaviour:
- Reset (async, rst=1): state IDLE, ps=00, FIFO emptied; all outputs 0 (readyForTransfer, dataValid, byteCount, frameError, overflow, dataOutByte). Synchronizers, shift register and counters are cleared. Reset mid-byte discards the partial byte.
- Input conditioning: serialClkIn and serialDataIn each pass through a 2-flop synchronizer. Sample event = synchronized clock high AND previous synchronized clock low. Data is taken from the synchronized data line in the same cycle. The scanner holds dataOut stable for >= 3 clk around each clkOut rise.
- States: IDLE=00, READY=01, RECEIVE=10.
  - IDLE -> READY when free space (FIFO_DEPTH - byteCount) >= BURST_BYTES, evaluated on registered count.
  - READY -> RECEIVE on the first sample event; that bit is shifted in.
  - RECEIVE -> IDLE after BURST_BYTES bytes are committed, or on timeout.
- readyForTransfer = 1 exactly in READY and RECEIVE; it drops in the cycle the state returns to IDLE.
- Shifting: shiftReg <= {shiftReg[DATA_WIDTH-2:0], bit}. A bitCount of 0..DATA_WIDTH-1 wraps to 0 on the 8th bit. The byte is written to the FIFO on that same edge.
- Latency: a serialClkIn rise first captured at edge t0 is shifted in at edge t0+2. On the final bit, dataValid/byteCount update after edge t0+2.
- Timeout: in RECEIVE, an idle counter counts cycles since the last sample event and resets on each event. On reaching TIMEOUT_CYCLES:
  - frameError pulses high for 1 cycle;
  - the partial byte is discarded, bitCount=0;
  - bytes already committed are kept;
  - state -> IDLE.
- FIFO:
  - dataOutByte always shows the head; it is 0 when empty.
  - Pop on readEnable & dataValid; a pop when empty is ignored.
  - Simultaneous push and pop: both occur, byteCount unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push when full: data dropped, overflow set until reset. This is unreachable in legal operation because READY requires room.
- Bursts are back-to-back capable: IDLE re-enters READY on the next edge if space allows.

Decomposition:
- Shared package: state encodings (IDLE/READY/RECEIVE) and default DATA_WIDTH; reuse the same 2-bit ps encoding style as scanner debug.
- One sub-module: byte_fifo, parameterized by width/depth, with push, pop, full, empty and count. Synchronizers, edge detect, FSM and timeout stay in the top.

Test Plan:
- Reset: hold rst for 2 edges. All outputs must be 0 and ps=00. First edge after release gives ps=01 and readyForTransfer=1.
- Nominal burst: send 0xA5 then 0x3C MSB-first with serialClkIn period 10 clk. Expect byteCount=2, dataOutByte=A5; pop gives 3C; pop gives dataValid=0. ps returns 00 then 01.
- Full queue: four bursts with no reads. Expect byteCount=8 and ps stays 00 with readyForTransfer=0. Pop 2 bytes and expect ps=01 on the following edge.
- Timeout: send 5 bits then idle for 64 clk. Expect one-cycle frameError, byteCount unchanged, ps 10->00->01. Next burst 0x81 is received exactly.
- Simultaneous push/pop with byteCount=3 during the final bit. byteCount stays 3, FIFO order is intact, and overflow=0.
- Reset mid-byte after 4 bits. Everything clears; a subsequent burst 0xF0 is received aligned from bit 7.

Source files
------------

// File: rtl/transfer_receiver_pkg.sv
// Shared definitions for the serial transfer receiver.
// rxState_t : 2-bit FSM encoding, exported on the ps debug port
//             (same style as the scanner's debug state)
// DEFAULT_DATA_WIDTH : default byte width for the receiver and its queue
package transfer_receiver_pkg;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'b00,
    RX_READY   = 2'b01,
    RX_RECEIVE = 2'b10
  } rxState_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/transfer_receiver_byte_fifo.sv
// byte_fifo: small synchronous FIFO for received bytes.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write request, pushData is the byte to write
//   pop        : read request, ignored while empty
//   head       : current head entry, 0 while empty
//   full/empty : occupancy flags
//   count      : number of stored entries (0..DEPTH)
//   overflow   : sticky, set when a push is attempted while full
// DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo
  import transfer_receiver_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign head   = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (doPush && !doPop) begin
        count <= count + 1'b1;
      end else if (doPop && !doPush) begin
        count <= count - 1'b1;
      end
      if (push && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/transfer_receiver.sv
// transfer_receiver: receiving end of the scanner serial transfer link.
// Grants transfers via readyForTransfer, deserializes serialClkIn /
// serialDataIn MSB-first into bytes and queues them in byte_fifo.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   serialClkIn       : scanner clkOut, data sampled on its rising edge
//   serialDataIn      : scanner dataOut, MSB first
//   readEnable        : consumer pop request
//   readyForTransfer  : to scanner readyForTransferIn (READY/RECEIVE)
//   dataOutByte       : queue head, 0 when empty
//   dataValid         : queue not empty
//   byteCount         : queue occupancy
//   frameError        : one-cycle pulse when a partial byte times out
//   overflow          : sticky, write attempted while queue full
//   ps                : current FSM state for debug
module transfer_receiver
  import transfer_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned BURST_BYTES    = 2,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serialClkIn,
  input  logic                          serialDataIn,
  input  logic                          readEnable,
  output logic                          readyForTransfer,
  output logic [DATA_WIDTH-1:0]         dataOutByte,
  output logic                          dataValid,
  output logic [$clog2(FIFO_DEPTH):0]   byteCount,
  output logic                          frameError,
  output logic                          overflow,
  output logic [1:0]                    ps
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BCW = $clog2(DATA_WIDTH);
  localparam int unsigned BYW = $clog2(BURST_BYTES) + 1;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [CW-1:0]  MAX_FILL     = CW'(FIFO_DEPTH - BURST_BYTES);
  localparam logic [BCW-1:0] LAST_BIT     = BCW'(DATA_WIDTH - 1);
  localparam logic [BYW-1:0] LAST_BYTE    = BYW'(BURST_BYTES - 1);
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  rxState_t              state;
  logic                  clkSync1;
  logic                  clkSync2;
  logic                  clkPrev;
  logic                  dataSync1;
  logic                  dataSync2;
  logic                  sampleEvent;
  logic [DATA_WIDTH-2:0] shiftReg;
  logic [DATA_WIDTH-1:0] nextByte;
  logic [BCW-1:0]        bitCount;
  logic [BYW-1:0]        byteIdx;
  logic [TW-1:0]         idleCnt;
  logic                  pushByte;
  logic                  fifoFull;
  logic                  fifoEmpty;

  // Two-flop synchronizers plus a delayed copy of the synchronized clock
  // for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkSync1  <= 1'b0;
      clkSync2  <= 1'b0;
      clkPrev   <= 1'b0;
      dataSync1 <= 1'b0;
      dataSync2 <= 1'b0;
    end else begin
      clkSync1  <= serialClkIn;
      clkSync2  <= clkSync1;
      clkPrev   <= clkSync2;
      dataSync1 <= serialDataIn;
      dataSync2 <= dataSync1;
    end
  end

  assign sampleEvent = clkSync2 & ~clkPrev;

  // shiftReg only holds the DATA_WIDTH-1 bits received so far; the
  // completed byte is formed combinationally so it can be pushed on the
  // same edge that shifts in the last bit.
  assign nextByte = {shiftReg, dataSync2};
  assign pushByte = sampleEvent && (state == RX_RECEIVE) && (bitCount == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= RX_IDLE;
      readyForTransfer <= 1'b0;
      frameError       <= 1'b0;
      shiftReg         <= '0;
      bitCount         <= '0;
      byteIdx          <= '0;
      idleCnt          <= '0;
    end else begin
      frameError <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (byteCount <= MAX_FILL) begin
            state            <= RX_READY;
            readyForTransfer <= 1'b1;
          end
        end
        RX_READY: begin
          if (sampleEvent) begin
            state    <= RX_RECEIVE;
            shiftReg <= nextByte[DATA_WIDTH-2:0];
            bitCount <= bitCount + 1'b1;
            byteIdx  <= '0;
            idleCnt  <= '0;
          end
        end
        RX_RECEIVE: begin
          if (sampleEvent) begin
            shiftReg <= nextByte[DATA_WIDTH-2:0];
            idleCnt  <= '0;
            if (bitCount == LAST_BIT) begin
              bitCount <= '0;
              if (byteIdx == LAST_BYTE) begin
                byteIdx          <= '0;
                state            <= RX_IDLE;
                readyForTransfer <= 1'b0;
              end else begin
                byteIdx <= byteIdx + 1'b1;
              end
            end else begin
              bitCount <= bitCount + 1'b1;
            end
          end else if (idleCnt == TIMEOUT_LAST) begin
            // Abandon the partial byte; committed bytes stay queued.
            frameError       <= 1'b1;
            shiftReg         <= '0;
            bitCount         <= '0;
            byteIdx          <= '0;
            idleCnt          <= '0;
            state            <= RX_IDLE;
            readyForTransfer <= 1'b0;
          end else begin
            idleCnt <= idleCnt + 1'b1;
          end
        end
        default: begin
          state            <= RX_IDLE;
          readyForTransfer <= 1'b0;
        end
      endcase
    end
  end

  assign ps        = state;
  assign dataValid = ~fifoEmpty;

  byte_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) rxFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushByte),
    .pushData (nextByte),
    .pop      (readEnable),
    .head     (dataOutByte),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (byteCount),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_transfer_receiver.sv
// Directed bench for transfer_receiver: expected bytes are queued when a
// byte is sent and checked by a monitor whenever the consumer pops.
`timescale 1ns/1ps
module tb_transfer_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serialClkIn = 1'b0;
  logic       serialDataIn = 1'b0;
  logic       readEnable = 1'b0;
  logic       readyForTransfer;
  logic [7:0] dataOutByte;
  logic       dataValid;
  logic [3:0] byteCount;
  logic       frameError;
  logic       overflow;
  logic [1:0] ps;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] expQ[$];
  bit         sawIdle = 1'b0;

  always #5 clk = ~clk;

  transfer_receiver #(
    .DATA_WIDTH     (8),
    .BURST_BYTES    (2),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .serialClkIn      (serialClkIn),
    .serialDataIn     (serialDataIn),
    .readEnable       (readEnable),
    .readyForTransfer (readyForTransfer),
    .dataOutByte      (dataOutByte),
    .dataValid        (dataValid),
    .byteCount        (byteCount),
    .frameError       (frameError),
    .overflow         (overflow),
    .ps               (ps)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pop happens on the next rising edge, so compare the head now.
  always @(negedge clk) begin
    if (ps == 2'b00) sawIdle = 1'b1;
    if (!rst && readEnable && dataValid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", dataOutByte);
      end else begin
        check("pop_data", dataOutByte, expQ.pop_front());
      end
    end
  end

  // One serial bit: data set 3 clk before the rise, clock high 5, low 2.
  // The rise is captured at the 1st edge after it and committed at the 3rd.
  task automatic sendBit(input bit b, input bit popOnCommit);
    serialDataIn = b;
    repeat (3) tick;
    serialClkIn = 1'b1;
    tick;
    tick;
    if (popOnCommit) readEnable = 1'b1;
    tick;
    if (popOnCommit) begin
      readEnable = 1'b0;
      check("pushpop_count", byteCount, 3);
      check("pushpop_overflow", overflow, 0);
    end
    tick;
    tick;
    serialClkIn = 1'b0;
    tick;
    tick;
  endtask

  task automatic sendByte(input logic [7:0] v, input bit popOnLast);
    expQ.push_back(v);
    for (int i = 7; i >= 0; i--) begin
      sendBit(v[i], popOnLast && (i == 0));
    end
  endtask

  task automatic sendBurst(input logic [7:0] a, input logic [7:0] b);
    sendByte(a, 1'b0);
    sendByte(b, 1'b0);
  endtask

  task automatic drain;
    int n;
    n = 0;
    readEnable = 1'b1;
    while (dataValid && n < 20) begin
      tick;
      n++;
    end
    readEnable = 1'b0;
    check("drain_empty", dataValid, 0);
    check("drain_scoreboard", expQ.size(), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_ready"}, readyForTransfer, 0);
    check({tag, "_valid"}, dataValid, 0);
    check({tag, "_count"}, byteCount, 0);
    check({tag, "_ferr"}, frameError, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_data"}, dataOutByte, 0);
    check({tag, "_ps"}, ps, 0);
  endtask

  initial begin
    int n;

    // Reset held for two edges.
    rst = 1'b1;
    tick;
    tick;
    checkResetOutputs("reset");
    rst = 1'b0;
    tick;
    check("post_reset_ps", ps, 2'b01);
    check("post_reset_ready", readyForTransfer, 1);

    // Nominal burst.
    sawIdle = 1'b0;
    sendBurst(8'hA5, 8'h3C);
    tick;
    check("nominal_count", byteCount, 2);
    check("nominal_head", dataOutByte, 8'hA5);
    check("nominal_saw_idle", sawIdle, 1);
    check("nominal_ps", ps, 2'b01);
    readEnable = 1'b1;
    tick;
    readEnable = 1'b0;
    check("nominal_head2", dataOutByte, 8'h3C);
    readEnable = 1'b1;
    tick;
    readEnable = 1'b0;
    check("nominal_empty", dataValid, 0);

    // Full queue.
    sendBurst(8'h11, 8'h22);
    sendBurst(8'h33, 8'h44);
    sendBurst(8'h55, 8'h66);
    sendBurst(8'h77, 8'h88);
    repeat (3) tick;
    check("full_count", byteCount, 8);
    check("full_ps", ps, 2'b00);
    check("full_ready", readyForTransfer, 0);
    check("full_ovf", overflow, 0);
    readEnable = 1'b1;
    tick;
    tick;
    readEnable = 1'b0;
    check("full_pop2_count", byteCount, 6);
    check("full_pop2_ps_still_idle", ps, 2'b00);
    tick;
    check("full_reenter_ps", ps, 2'b01);
    check("full_reenter_ready", readyForTransfer, 1);
    drain;

    // Timeout after 5 bits.
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    check("timeout_receiving_ps", ps, 2'b10);
    n = 0;
    while (!frameError && n < 100) begin
      tick;
      n++;
    end
    check("timeout_seen", frameError, 1);
    check("timeout_delay", n, 60);
    check("timeout_ps_idle", ps, 2'b00);
    check("timeout_count", byteCount, 0);
    tick;
    check("timeout_pulse_width", frameError, 0);
    check("timeout_ps_ready", ps, 2'b01);
    sendBurst(8'h81, 8'h7E);
    tick;
    check("timeout_next_count", byteCount, 2);
    check("timeout_next_head", dataOutByte, 8'h81);
    drain;

    // Simultaneous push and pop on the final bit with three bytes queued.
    sendBurst(8'hC3, 8'h5A);
    sendByte(8'h96, 1'b0);
    sendByte(8'h69, 1'b1);
    tick;
    check("pushpop_count_after", byteCount, 3);
    check("pushpop_head", dataOutByte, 8'h5A);
    drain;

    // Reset in the middle of a byte.
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    rst = 1'b1;
    tick;
    tick;
    checkResetOutputs("midreset");
    rst = 1'b0;
    tick;
    check("midreset_ps", ps, 2'b01);
    sendBurst(8'hF0, 8'h0F);
    tick;
    check("midreset_count", byteCount, 2);
    check("midreset_head", dataOutByte, 8'hF0);
    drain;
    check("final_ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
